// File: rtl/mem_port_arb3.sv
// -----------------------------------------------------------------------------
// mem_port_arb3
//
// Three-way round-robin arbiter for a single shared memory/bus port.
// Requesters: 0 = instruction fetch, 1 = data access, 2 = auxiliary/DMA.
// One transaction is in flight at a time (IDLE -> BUSY -> DONE -> IDLE).
// The registered `sel` steers the Mux3 instances feeding address, write data
// and control onto the shared port. A watchdog aborts any transaction that
// stays BUSY for MAX_WAIT cycles without `mem_ready`.
//
// Parameters:
//   MAX_WAIT   BUSY-cycle limit before timeout; 0 disables the watchdog.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[2:0]   level requests, held until that requester's done/err
//   mem_ready  shared port completion, only looked at in BUSY
//   sel[1:0]   Mux3 select of the current/last owner (never 2'b11)
//   grant[2:0] one-hot owner of the port, 000 when none
//   mem_valid  transaction active on the shared port
//   done[2:0]  one-cycle completion pulse to the owner
//   err[2:0]   one-cycle timeout pulse to the owner
//   busy       high in BUSY and DONE
// -----------------------------------------------------------------------------
module mem_port_arb3 #(
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       mem_ready,
  output logic [1:0] sel,
  output logic [2:0] grant,
  output logic       mem_valid,
  output logic [2:0] done,
  output logic [2:0] err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A disabled watchdog still gets a 1-bit counter so no zero-width vector exists.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  // Counter reads k-1 during BUSY cycle k, so this value marks cycle MAX_WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  state_t           state_q,     state_d;
  logic [1:0]       ptr_q,       ptr_d;
  logic [CNT_W-1:0] wd_cnt_q,    wd_cnt_d;
  logic [1:0]       sel_q,       sel_d;
  logic [2:0]       grant_q,     grant_d;
  logic             mem_valid_q, mem_valid_d;
  logic [2:0]       done_q,      done_d;
  logic [2:0]       err_q,       err_d;
  logic             busy_q,      busy_d;

  logic [1:0]       winner;
  logic             timeout;

  // Modulo-3 increment of a requester index.
  function automatic logic [1:0] next3(input logic [1:0] x);
    next3 = (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First active request scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    idx     = p;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = next3(idx);
    end
  endfunction

  assign winner  = rr_pick(req, ptr_q);
  assign timeout = (MAX_WAIT != 0) && (wd_cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    wd_cnt_d    = wd_cnt_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    mem_valid_d = mem_valid_q;
    done_d      = 3'b000;
    err_d       = 3'b000;

    unique case (state_q)
      S_IDLE: begin
        if (req != 3'b000) begin
          state_d     = S_BUSY;
          sel_d       = winner;
          grant_d     = 3'b001 << winner;
          mem_valid_d = 1'b1;
          ptr_d       = next3(winner);
          wd_cnt_d    = '0;
        end
      end

      S_BUSY: begin
        // Completion takes precedence over a timeout in the same cycle.
        // grant_q is the owner one-hot, so it doubles as the pulse pattern.
        if (mem_ready) begin
          state_d     = S_DONE;
          done_d      = grant_q;
          grant_d     = 3'b000;
          mem_valid_d = 1'b0;
        end else if (timeout) begin
          state_d     = S_DONE;
          err_d       = grant_q;
          grant_d     = 3'b000;
          mem_valid_d = 1'b0;
        end else begin
          wd_cnt_d    = wd_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Requests are ignored here so the finishing owner cannot be re-granted.
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        grant_d     = 3'b000;
        mem_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state uses non-blocking assignments so all flops update from the
  // same pre-edge values; the reset clears every flop, including the pointer
  // and watchdog, so a killed transaction leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      wd_cnt_q    <= '0;
      sel_q       <= 2'd0;
      grant_q     <= 3'b000;
      mem_valid_q <= 1'b0;
      done_q      <= 3'b000;
      err_q       <= 3'b000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wd_cnt_q    <= wd_cnt_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign mem_valid = mem_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arb3.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arb3
//
// Directed bench for mem_port_arb3 (MAX_WAIT = 4). Each vector drives
// {rst, req, mem_ready} for one cycle, lets one rising edge pass, and compares
// the registered outputs {sel, grant, mem_valid, done, err, busy} against a
// hand-computed value. A table covers the basic grant and the round-robin
// rotation; hand-written sequences cover the watchdog, reset and the
// ignored-input corner cases.
// -----------------------------------------------------------------------------
module tb_mem_port_arb3;

  localparam int MAX_WAIT = 4;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       mem_ready;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       mem_valid;
  logic [2:0] done;
  logic [2:0] err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arb3 #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mem_ready (mem_ready),
    .sel       (sel),
    .grant     (grant),
    .mem_valid (mem_valid),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] req;
    logic       mr;
    logic [12:0] exp;   // {sel, grant, mem_valid, done, err, busy}
  } vec_t;

  vec_t tbl[$];

  function automatic logic [12:0] o(input logic [1:0] s, input logic [2:0] g,
                                    input logic v, input logic [2:0] d,
                                    input logic [2:0] e, input logic b);
    o = {s, g, v, d, e, b};
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic [2:0] rq,
                              input logic m, input logic [12:0] ex);
    vec_t t;
    t.name = nm; t.rst = r; t.req = rq; t.mr = m; t.exp = ex;
    return t;
  endfunction

  // Drive one cycle of inputs, pass one edge, sample 1 time unit later.
  task automatic apply(input string nm, input logic r, input logic [2:0] rq,
                       input logic m, input logic [12:0] ex);
    logic [12:0] got;
    rst = r; req = rq; mem_ready = m;
    @(posedge clk);
    #1;
    got = {sel, grant, mem_valid, done, err, busy};
    n_vec++;
    if (got !== ex) begin
      n_err++;
      $display("FAIL %s: got sel=%b grant=%b valid=%b done=%b err=%b busy=%b, expected sel=%b grant=%b valid=%b done=%b err=%b busy=%b",
               nm, got[12:11], got[10:8], got[7], got[6:4], got[3:1], got[0],
               ex[12:11], ex[10:8], ex[7], ex[6:4], ex[3:1], ex[0]);
    end
  endtask

  // Frequently used expected patterns.
  function automatic logic [12:0] busy_v(input logic [1:0] s);
    busy_v = o(s, 3'b001 << s, 1'b1, 3'b000, 3'b000, 1'b1);
  endfunction
  function automatic logic [12:0] done_v(input logic [1:0] s);
    done_v = o(s, 3'b000, 1'b0, 3'b001 << s, 3'b000, 1'b1);
  endfunction
  function automatic logic [12:0] err_v(input logic [1:0] s);
    err_v = o(s, 3'b000, 1'b0, 3'b000, 3'b001 << s, 1'b1);
  endfunction
  function automatic logic [12:0] idle_v(input logic [1:0] s);
    idle_v = o(s, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
  endfunction

  initial begin
    rst = 1'b1; req = 3'b000; mem_ready = 1'b0;

    // Single grant to requester 1, completion in its 3rd BUSY cycle.
    tbl.push_back(mk("reset_state",  1, 3'b000, 0, idle_v(2'd0)));
    tbl.push_back(mk("r1_grant",     0, 3'b010, 0, busy_v(2'd1)));
    tbl.push_back(mk("r1_busy2",     0, 3'b010, 0, busy_v(2'd1)));
    tbl.push_back(mk("r1_busy3",     0, 3'b010, 0, busy_v(2'd1)));
    tbl.push_back(mk("r1_done",      0, 3'b010, 1, done_v(2'd1)));
    tbl.push_back(mk("r1_idle",      0, 3'b000, 0, idle_v(2'd1)));
    // Round-robin rotation with all three requesting.
    tbl.push_back(mk("rr_reset",     1, 3'b000, 0, idle_v(2'd0)));
    tbl.push_back(mk("rr_grant0",    0, 3'b111, 0, busy_v(2'd0)));
    tbl.push_back(mk("rr_done0",     0, 3'b111, 1, done_v(2'd0)));
    tbl.push_back(mk("rr_idle0",     0, 3'b110, 0, idle_v(2'd0)));
    tbl.push_back(mk("rr_grant1",    0, 3'b110, 0, busy_v(2'd1)));
    tbl.push_back(mk("rr_done1",     0, 3'b110, 1, done_v(2'd1)));
    tbl.push_back(mk("rr_idle1",     0, 3'b100, 0, idle_v(2'd1)));
    tbl.push_back(mk("rr_grant2",    0, 3'b100, 0, busy_v(2'd2)));
    tbl.push_back(mk("rr_done2",     0, 3'b100, 1, done_v(2'd2)));
    tbl.push_back(mk("rr_idle2",     0, 3'b000, 0, idle_v(2'd2)));
    tbl.push_back(mk("rr_wrap0",     0, 3'b111, 0, busy_v(2'd0)));
    tbl.push_back(mk("rr_wrap_done", 0, 3'b111, 1, done_v(2'd0)));
    tbl.push_back(mk("rr_wrap_pick1",0, 3'b110, 0, idle_v(2'd0)));
    tbl.push_back(mk("rr_next1",     0, 3'b110, 0, busy_v(2'd1)));

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i].name, tbl[i].rst, tbl[i].req, tbl[i].mr, tbl[i].exp);

    // Watchdog: mem_ready never comes, valid for exactly MAX_WAIT cycles.
    apply("wd_reset", 1, 3'b000, 0, idle_v(2'd0));
    for (int k = 0; k < MAX_WAIT; k++) apply("wd_busy", 0, 3'b001, 0, busy_v(2'd0));
    apply("wd_err",  0, 3'b001, 0, err_v(2'd0));
    apply("wd_idle", 0, 3'b000, 0, idle_v(2'd0));

    // mem_ready in the timeout cycle: completion wins.
    apply("race_reset", 1, 3'b000, 0, idle_v(2'd0));
    for (int k = 0; k < MAX_WAIT; k++) apply("race_busy", 0, 3'b001, 0, busy_v(2'd0));
    apply("race_done", 0, 3'b001, 1, done_v(2'd0));
    apply("race_idle", 0, 3'b000, 0, idle_v(2'd0));

    // Reset in the 2nd BUSY cycle of a requester-2 transaction.
    apply("kill_reset",  1, 3'b000, 0, idle_v(2'd0));
    apply("kill_grant2", 0, 3'b100, 0, busy_v(2'd2));
    apply("kill_busy2",  0, 3'b100, 0, busy_v(2'd2));
    apply("kill_rst",    1, 3'b100, 0, idle_v(2'd0));
    apply("kill_quiet",  0, 3'b000, 0, idle_v(2'd0));
    apply("kill_req110", 0, 3'b110, 0, busy_v(2'd1));
    // Pointer now 2; after a reset it must be 0 again, so 101 picks requester 0.
    apply("ptr_rst",     1, 3'b000, 0, idle_v(2'd0));
    apply("ptr_req101",  0, 3'b101, 0, busy_v(2'd0));
    apply("ptr_done",    0, 3'b101, 1, done_v(2'd0));
    apply("ptr_idle",    0, 3'b100, 0, idle_v(2'd0));

    // mem_ready in IDLE/DONE ignored; owner dropping req mid-BUSY ignored.
    apply("ign_reset",    1, 3'b000, 0, idle_v(2'd0));
    apply("ign_mr_idle",  0, 3'b000, 1, idle_v(2'd0));
    apply("ign_grant1",   0, 3'b010, 0, busy_v(2'd1));
    apply("ign_drop_req", 0, 3'b000, 0, busy_v(2'd1));
    apply("ign_done",     0, 3'b000, 1, done_v(2'd1));
    apply("ign_mr_done",  0, 3'b000, 1, idle_v(2'd1));
    apply("ign_no_repeat",0, 3'b000, 1, idle_v(2'd1));
    // New request held through DONE is served in the next IDLE.
    apply("q_grant2",     0, 3'b100, 0, busy_v(2'd2));
    apply("q_done2",      0, 3'b101, 1, done_v(2'd2));
    apply("q_idle",       0, 3'b001, 0, idle_v(2'd2));
    apply("q_grant0",     0, 3'b001, 0, busy_v(2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time bound so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
